// File: rtl/alu_pkg.sv
/*------------------------------------------------------------------
 * alu_pkg : shared op-codes, error codes and divider state encoding
 * Rev 1.0
 *----------------------------------------------------------------*/
`default_nettype none

package alu_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_OUT_W = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;

  // Divide-by-zero lives in bit 1 of the breadboard err_code.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
/*------------------------------------------------------------------
 * div_step : one combinational restoring-division iteration
 * Rev 1.0
 *----------------------------------------------------------------*/
`default_nettype none

module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] rem_i,
  input  logic           bit_i,
  input  logic [WIDTH:0] dvs_i,
  output logic [WIDTH:0] rem_o,
  output logic           q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, dvs_i};

  always_comb begin
    q_o   = 1'b0;
    rem_o = shifted[WIDTH:0];
    if (shifted >= {1'b0, dvs_i}) begin
      q_o   = 1'b1;
      rem_o = diff[WIDTH:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
/*------------------------------------------------------------------
 * seq_divider : multi-cycle signed restoring divider, valid/ready I/O
 * Rev 1.0
 *----------------------------------------------------------------*/
`default_nettype none

module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] quotient,
  output logic [OUT_W-1:0] remainder,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [OUT_W-1:0] quo_q, quo_d;
  logic [OUT_W-1:0] rmd_q, rmd_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [OUT_W-1:0] q_mag, r_mag;

  // Unsigned W-bit magnitude still holds 2^(W-1) for the most negative input.
  assign dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  assign q_mag   = OUT_W'(dvd_q);
  assign r_mag   = OUT_W'(rem_q);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dvd_mag;
          dvs_d   = {1'b0, dvs_mag};
          negq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          negr_d  = dividend[WIDTH-1];
          count_d = '0;
          rem_d   = '0;
          if (divisor == '0) begin
            quo_d   = '0;
            rmd_d   = OUT_W'($signed(dividend));
            err_d   = ERR_DIV0[1];
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Quotient bits shift into the vacated dividend LSBs.
        rem_d   = step_rem;
        dvd_d   = {dvd_q[WIDTH-2:0], step_q};
        count_d = count_q + 1'b1;
        if (count_q == LAST) state_d = FIX;
      end
      FIX: begin
        quo_d   = negq_q ? (~q_mag + 1'b1) : q_mag;
        rmd_d   = negr_q ? (~r_mag + 1'b1) : r_mag;
        err_d   = ERR_NONE[1];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
/*------------------------------------------------------------------
 * tb_seq_divider : directed and randomised self-checking bench
 * Rev 1.0
 *----------------------------------------------------------------*/
`default_nettype none

module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] res_q, res_r;
  logic        res_e;
  int          res_lat;

  seq_divider #(.WIDTH(16), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the result, capture it; no release.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'h5A5A;
    divisor  = 16'h0003;
    res_lat  = 1;
    while (!out_valid && res_lat < 40) begin
      @(posedge clk); #1;
      res_lat++;
    end
    res_q = quotient;
    res_r = remainder;
    res_e = err;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ee,
                          input int elat);
    issue(a, b);
    chk({tag, " lat"}, 32'(res_lat), 32'(elat));
    chk({tag, " q"}, res_q, eq);
    chk({tag, " r"}, res_r, er);
    chk({tag, " err"}, {31'd0, res_e}, {31'd0, ee});
    release_out();
  endtask

  task automatic modelled(input logic [15:0] a, input logic [15:0] b);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) begin
      qi = 0;
      ri = ai;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
    end
    issue(a, b);
    chk("rnd lat", 32'(res_lat), (bi == 0) ? 32'd1 : 32'd18);
    chk("rnd q", res_q, 32'(qi));
    chk("rnd r", res_r, 32'(ri));
    chk("rnd err", {31'd0, res_e}, (bi == 0) ? 32'd1 : 32'd0);
    release_out();
  endtask

  logic [15:0] bnd [6];

  initial begin
    bnd[0] = 16'sd0;  bnd[1] = 16'sd1;     bnd[2] = -16'sd1;
    bnd[3] = 16'sd32767; bnd[4] = 16'h8000; bnd[5] = 16'sd2;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst quotient", quotient, 32'd0);
    chk("rst remainder", remainder, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);

    directed("32000/16000", 16'd32000, 16'd16000, 32'd2, 32'd0, 1'b0, 18);
    chk("idle in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle out_valid", {31'd0, out_valid}, 32'd0);
    chk("held quotient", quotient, 32'd2);
    directed("11/0", 16'd11, 16'd0, 32'd0, 32'd11, 1'b1, 1);
    directed("11/15", 16'd11, 16'd15, 32'd0, 32'd11, 1'b0, 18);
    directed("-7/2", -16'sd7, 16'sd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 18);
    directed("7/-2", 16'sd7, -16'sd2, 32'hFFFF_FFFD, 32'd1, 1'b0, 18);
    directed("-7/-2", -16'sd7, -16'sd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 18);
    directed("-32768/-1", 16'h8000, 16'hFFFF, 32'd32768, 32'd0, 1'b0, 18);
    directed("-5/0", -16'sd5, 16'd0, 32'd0, 32'hFFFF_FFFB, 1'b1, 1);

    // Backpressure: result held, new requests ignored while in DONE.
    issue(16'd100, 16'd9);
    chk("bp first q", res_q, 32'd11);
    chk("bp first r", res_r, 32'd1);
    dividend = 16'd50;
    divisor  = 16'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp quotient", quotient, 32'd11);
      chk("bp remainder", remainder, 32'd1);
    end
    in_valid = 1'b0;
    release_out();
    chk("bp release in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp kept quotient", quotient, 32'd11);

    // Reset during iteration 8 of 100/7.
    dividend = 16'd100;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst quotient", quotient, 32'd0);
    chk("midrst remainder", remainder, 32'd0);
    chk("midrst err", {31'd0, err}, 32'd0);
    directed("100/7", 16'd100, 16'd7, 32'd14, 32'd2, 1'b0, 18);

    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        modelled(bnd[i], bnd[j]);

    for (int i = 0; i < 2000; i++)
      modelled(16'($urandom), ($urandom_range(0, 15) == 0) ? bnd[$urandom_range(0, 5)]
                                                            : 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed divider producing quotient and remainder together; the sequential inverse of the combinational multiplier.
- Replaces the combinational while-loop divide and modulo paths on the breadboard's op 3 (div) and op 4 (mod) results.
- Valid/ready handshake on both input and output, so the breadboard sequencer can stall on it.
- One restoring-division step per clock, with sign fix-up at the end.

Parameters:
- WIDTH, 16, operand width in bits (two's complement).
- OUT_W, 32, result width; must be >= WIDTH+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and request present
- in_ready  out  1  block can accept a request
- dividend  in  WIDTH  signed dividend
- divisor  in  WIDTH  signed divisor
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer takes result
- quotient  out  OUT_W  signed quotient, truncated toward zero
- remainder  out  OUT_W  signed remainder, sign follows dividend
- err  out  1  divide-by-zero flag, qualified by out_valid

Behaviour:
- Reset (rst high at a rising edge): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, err=0, iteration count=0. Reset wins over every other event, including mid-CALC; any partial result is discarded.
- in_ready = (state==IDLE), registered-state decode only; no combinational path from out_ready.
- Accept: in_valid && in_ready at an edge. Latch |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - divisor==0: go to DONE; quotient=0, remainder=sign-extended dividend, err=1.
  - Otherwise: go to CALC with count=0 and partial remainder=0.
- CALC, one step per edge, WIDTH edges total:
  - Shift {partial remainder, dividend register} left by 1.
  - If partial remainder >= |divisor|, subtract and set the new quotient LSB to 1; else set it to 0.
  - count increments; on count==WIDTH-1, go to FIX.
- Magnitudes are WIDTH+1 bits so that |-2^(WIDTH-1)| is representable.
- FIX, one edge:
  - quotient = sign_q ? -q : q, sign-extended to OUT_W.
  - remainder = sign_r ? -r : r, sign-extended.
  - err=0; go to DONE.
- DONE: out_valid=1; quotient, remainder and err held stable while out_ready=0. On out_ready at an edge, go to IDLE and out_valid=0 next cycle. Output registers keep their last value after the handshake.
- Latency, counting the accepting edge:
  - normal: out_valid high after exactly WIDTH+2 edges (18 at default);
  - divide-by-zero: 1 edge.
- Throughput: one operation per WIDTH+3 cycles minimum. No accept while CALC, FIX or DONE. in_valid and operand changes outside the accept edge are ignored.
- Overflow: -2^(WIDTH-1) / -1 gives quotient +2^(WIDTH-1) in OUT_W, err=0 (hence OUT_W > WIDTH).
- Identity held for every non-error result: dividend = quotient*divisor + remainder, with |remainder| < |divisor|.
- Illegal state encodings return to IDLE.

Decomposition:
- Shared package alu_pkg:
  - op-code constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_MOD=4;
  - ERR_NONE/ERR_DIV0 error-code values matching breadboard err_code bit 1;
  - state enum {IDLE, CALC, FIX, DONE};
  - default WIDTH/OUT_W.
- One sub-module: div_step, combinational single restoring-division iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once and reused each CALC cycle.

Test Plan:
- 32000 / 16000 -> out_valid 18 edges after accept; quotient=2, remainder=0, err=0.
- 11 / 0 -> out_valid after 1 edge; quotient=0, remainder=11, err=1. Next request 11 / 15 -> quotient=0, remainder=11, err=0 (err cleared).
- Signs: -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1; -7/-2 -> q=3, r=-1; -32768/-1 -> q=32768, r=0, err=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs stable, in_ready=0, new in_valid ignored. Pulse out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-CALC: assert rst at iteration 8 of 100/7. Next cycle in_ready=1, out_valid=0, outputs 0. Then 100/7 -> q=14, r=2.
- Random 2000 signed operand pairs, plus boundaries 0, ±1, 32767, -32768 -> check the identity against a reference model, and latency exactly 18 (or 1 for zero divisor).
